// File: rtl/lcd_init_sequencer_if.sv
// lcd_init_sequencer_if: byte stream with DC flag over a valid/ready handshake
interface lcd_init_sequencer_if;
    logic       valid;
    logic       dc;
    logic [7:0] data;
    logic       ready;
    modport master (output valid, dc, data, input ready);
    modport slave (input valid, dc, data, output ready);
endinterface

// File: rtl/lcd_init_sequencer.sv
// lcd_init_sequencer: panel reset pulse and command ROM walk, then host pass-through; LCD_INIT_TIMEOUT_EN adds init_err stall timeout
module lcd_init_sequencer #(
    parameter int RST_PULSE_CYC  = 120,
    parameter int RST_WAIT_CYC   = 60000,
    parameter int DELAY_UNIT_CYC = 12000,
    parameter int ROM_DEPTH      = 32,
    parameter int TIMEOUT_CYC    = 65535
) (
    input  logic CLK,
    input  logic RESET,
    input  logic reinit,
    output logic LCD_RST,
    output logic init_done,
`ifdef LCD_INIT_TIMEOUT_EN
    output logic init_err,
`endif
    lcd_init_sequencer_if.master tx,
    lcd_init_sequencer_if.slave  host
);
    localparam int PW = $clog2(ROM_DEPTH);
    localparam int DW = 8 + $clog2(DELAY_UNIT_CYC + 1);
    localparam int AW = $clog2(RST_PULSE_CYC + RST_WAIT_CYC + TIMEOUT_CYC + 1);
    localparam int CW = DW > AW ? DW : AW;
    typedef enum logic [3:0] {
        RST_ASSERT, RST_WAIT, FETCH_CMD, FETCH_ARG, SEND_CMD,
        SEND_PARAM, LOAD_DLY, DELAY, RUN
    } state_t;
    state_t        state, state_n, after_send;
    logic [PW-1:0] ptr, ptr_n, ptr_inc;
    logic [CW-1:0] cnt, cnt_n, target;
    logic [7:0]    cmd_q, cmd_n, dly_q, dly_n, rom_byte;
    logic [3:0]    par_q, par_n;
    logic          dflag_q, dflag_n, send, hs, stall_to;
    function automatic logic [7:0] rom_at(input logic [PW-1:0] a);
        case (int'(a))
            0:  rom_at = 8'h11;
            1:  rom_at = 8'h80;
            2:  rom_at = 8'h78;
            3:  rom_at = 8'hB1;
            4:  rom_at = 8'h03;
            5:  rom_at = 8'h05;
            6:  rom_at = 8'h3C;
            7:  rom_at = 8'h3C;
            8:  rom_at = 8'h3A;
            9:  rom_at = 8'h01;
            10: rom_at = 8'h05;
            11: rom_at = 8'h29;
            12: rom_at = 8'h80;
            13: rom_at = 8'h14;
            default: rom_at = 8'h00;
        endcase
    endfunction
    assign rom_byte = rom_at(ptr);
    assign send     = state == SEND_CMD || state == SEND_PARAM;
    assign hs       = send && tx.ready;
`ifdef LCD_INIT_TIMEOUT_EN
    assign stall_to = send && !tx.ready && cnt == CW'(TIMEOUT_CYC - 1);
`else
    assign stall_to = 1'b0;
`endif
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cmd_n      = cmd_q;
        par_n      = par_q;
        dflag_n    = dflag_q;
        dly_n      = dly_q;
        ptr_inc    = ptr == PW'(ROM_DEPTH - 1) ? ptr : ptr + PW'(1);
        target     = CW'(dly_q) * CW'(DELAY_UNIT_CYC);
        after_send = dflag_q ? LOAD_DLY : FETCH_CMD;
        case (state)
            RST_ASSERT: state_n = cnt == CW'(RST_PULSE_CYC - 1) ? RST_WAIT : RST_ASSERT;
            RST_WAIT:   state_n = cnt == CW'(RST_WAIT_CYC - 1) ? FETCH_CMD : RST_WAIT;
            FETCH_CMD: begin
                // the last ROM slot is never fetched as a command, so an unterminated table still ends
                if (rom_byte == 8'h00 || ptr == PW'(ROM_DEPTH - 1)) state_n = RUN;
                else begin
                    cmd_n   = rom_byte;
                    ptr_n   = ptr_inc;
                    state_n = FETCH_ARG;
                end
            end
            FETCH_ARG: begin
                par_n   = rom_byte[3:0];
                dflag_n = rom_byte[7];
                ptr_n   = ptr_inc;
                state_n = SEND_CMD;
            end
            SEND_CMD: state_n = hs ? (par_q != 4'd0 ? SEND_PARAM : after_send) : SEND_CMD;
            SEND_PARAM: begin
                if (hs) begin
                    ptr_n   = ptr_inc;
                    par_n   = par_q - 4'd1;
                    state_n = par_q == 4'd1 ? after_send : SEND_PARAM;
                end
            end
            LOAD_DLY: begin
                dly_n   = rom_byte;
                ptr_n   = ptr_inc;
                state_n = rom_byte == 8'h00 ? FETCH_CMD : DELAY;
            end
            // counter runs since the final handshake; the +3 covers LOAD_DLY and the two fetch cycles
            DELAY: state_n = cnt + CW'(3) >= target ? FETCH_CMD : DELAY;
            RUN: begin
                if (reinit) begin
                    state_n = RST_ASSERT;
                    ptr_n   = '0;
                end
            end
            default: state_n = RST_ASSERT;
        endcase
        if (stall_to) state_n = RUN;
        cnt_n = (state == RUN || hs || (state_n != state && state != LOAD_DLY)) ? '0 : cnt + CW'(1);
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= RST_ASSERT;
            ptr     <= '0;
            cnt     <= '0;
            cmd_q   <= '0;
            dly_q   <= '0;
            par_q   <= '0;
            dflag_q <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            cmd_q   <= cmd_n;
            dly_q   <= dly_n;
            par_q   <= par_n;
            dflag_q <= dflag_n;
        end
    end
`ifdef LCD_INIT_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RESET || (state == RUN && reinit)) init_err <= 1'b0;
        else if (stall_to) init_err <= 1'b1;
    end
`endif
    always_comb begin
        LCD_RST    = state != RST_ASSERT;
        init_done  = state == RUN;
        tx.valid   = send || (state == RUN && host.valid);
        tx.dc      = state == SEND_PARAM || (state == RUN && host.dc);
        tx.data    = state == SEND_CMD ? cmd_q : state == SEND_PARAM ? rom_byte : state == RUN ? host.data : 8'h00;
        host.ready = state == RUN && tx.ready;
    end
endmodule

// File: tb/tb_lcd_init_sequencer.sv
// tb_lcd_init_sequencer: directed table-driven bench for lcd_init_sequencer
module tb_lcd_init_sequencer;
    typedef struct {logic dc; logic [7:0] data; int gap;} byte_t;
    typedef struct {logic dc; logic [7:0] data; int cyc;} cap_t;
    typedef struct {
        logic hv; logic hdc; logic [7:0] hd; logic rdy;
        logic ev; logic edc; logic [7:0] ed; logic ehr;
    } host_vec_t;
    logic CLK = 1'b0, RESET = 1'b1, reinit = 1'b0;
    logic LCD_RST, init_done;
`ifdef LCD_INIT_TIMEOUT_EN
    logic init_err;
`endif
    int checks = 0, failures = 0, cyc = 0, mode = 0;
    logic man_ready = 1'b1, rdy13 = 1'b0;
    cap_t cap[$];
    lcd_init_sequencer_if tx();
    lcd_init_sequencer_if host();
    lcd_init_sequencer #(
        .RST_PULSE_CYC(4), .RST_WAIT_CYC(8), .DELAY_UNIT_CYC(2), .ROM_DEPTH(32), .TIMEOUT_CYC(16)
    ) dut (
        .CLK(CLK), .RESET(RESET), .reinit(reinit), .LCD_RST(LCD_RST), .init_done(init_done),
`ifdef LCD_INIT_TIMEOUT_EN
        .init_err(init_err),
`endif
        .tx(tx), .host(host)
    );
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    assign tx.ready = mode == 0 ? 1'b1 : mode == 1 ? rdy13 : mode == 2 ? 1'b0 : man_ready;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask
    initial forever begin
        @(negedge CLK);
        rdy13 = (cyc % 3) == 0;
    end
    // monitor: records init bytes and checks the hold-until-accepted rule
    initial begin
        logic pend, pdc;
        logic [7:0] pdata;
        pend = 1'b0; pdc = 1'b0; pdata = 8'h00;
        forever begin
            @(negedge CLK);
            #2;
            if (RESET === 1'b0 && init_done === 1'b0) begin
                check("init_host_ready", host.ready, 0);
                if (pend) begin
                    check("hold_valid", tx.valid, 1);
                    check("hold_dc", tx.dc, pdc);
                    check("hold_data", tx.data, pdata);
                end
                if (tx.valid && tx.ready) cap.push_back('{tx.dc, tx.data, cyc});
                pend = tx.valid && !tx.ready;
                pdc = tx.dc;
                pdata = tx.data;
            end else pend = 1'b0;
        end
    end
    task automatic tick();
        @(negedge CLK);
        #2;
    endtask
    task automatic check_seq(input string nm, input byte_t exp_seq[8], input logic gaps);
        check({nm, "_len"}, cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) begin
            check($sformatf("%s_dc%0d", nm, i), cap[i].dc, exp_seq[i].dc);
            check($sformatf("%s_data%0d", nm, i), cap[i].data, exp_seq[i].data);
            if (gaps && i > 0) check($sformatf("%s_gap%0d", nm, i), cap[i].cyc - cap[i-1].cyc - 1, exp_seq[i].gap);
        end
    endtask
    initial begin
        byte_t exp_seq[8];
        host_vec_t hv[5];
        int n, done_cyc;
        exp_seq = '{'{1'b0, 8'h11, -1}, '{1'b0, 8'hB1, 240}, '{1'b1, 8'h05, 0}, '{1'b1, 8'h3C, 0},
                    '{1'b1, 8'h3C, 0}, '{1'b0, 8'h3A, 2}, '{1'b1, 8'h05, 0}, '{1'b0, 8'h29, 2}};
        hv = '{'{1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1},
               '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b0},
               '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1},
               '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1},
               '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0}};
        host.valid = 1'b1; host.dc = 1'b1; host.data = 8'hAA;
        repeat (3) @(negedge CLK);
        #2;
        check("rst_lcd_rst", LCD_RST, 0);
        check("rst_tx_valid", tx.valid, 0);
        check("rst_host_ready", host.ready, 0);
        check("rst_init_done", init_done, 0);
        @(negedge CLK);
        RESET = 1'b0;
        #2;
        n = 0;
        while (!LCD_RST && n < 50) begin n++; tick(); end
        check("rst_pulse_len", n, 4);
        n = 0;
        while (!tx.valid && n < 50) begin n++; tick(); end
        check("first_valid_delay", n, 10);
        n = 0;
        while (!init_done && n < 2000) begin n++; tick(); end
        check("init_done_full", init_done, 1);
        done_cyc = cyc;
        check_seq("seq", exp_seq, 1'b1);
        if (cap.size() == 8) check("final_delay", done_cyc - cap[7].cyc, 40);
        @(negedge CLK);
        mode = 3;
        foreach (hv[i]) begin
            @(negedge CLK);
            host.valid = hv[i].hv; host.dc = hv[i].hdc; host.data = hv[i].hd; man_ready = hv[i].rdy;
            #1;
            check($sformatf("host_valid%0d", i), tx.valid, hv[i].ev);
            check($sformatf("host_dc%0d", i), tx.dc, hv[i].edc);
            check($sformatf("host_data%0d", i), tx.data, hv[i].ed);
            check($sformatf("host_ready%0d", i), host.ready, hv[i].ehr);
        end
        @(negedge CLK);
        cap.delete();
        host.valid = 1'b1; host.dc = 1'b0; host.data = 8'h77; man_ready = 1'b1; reinit = 1'b1;
        #1;
        check("reinit_cycle_valid", tx.valid, 1);
        check("reinit_cycle_data", tx.data, 8'h77);
        check("reinit_cycle_ready", host.ready, 1);
        @(negedge CLK);
        reinit = 1'b0; mode = 1; host.dc = 1'b1; host.data = 8'hAA;
        #2;
        check("reinit_done_low", init_done, 0);
        n = 0;
        while (!LCD_RST && n < 50) begin n++; tick(); end
        check("reinit_pulse_len", n, 4);
        n = 0;
        while (cap.size() == 0 && n < 100) begin n++; tick(); end
        check("replay_started", cap.size() > 0, 1);
        repeat (20) @(negedge CLK);
        reinit = 1'b1;
        @(negedge CLK);
        reinit = 1'b0;
        #2;
        check("delay_reinit_lcd_rst", LCD_RST, 1);
        check("delay_reinit_valid", tx.valid, 0);
        check("delay_reinit_done", init_done, 0);
        n = 0;
        while (!init_done && n < 3000) begin n++; tick(); end
        check("init_done_bp", init_done, 1);
        check_seq("bp_seq", exp_seq, 1'b0);
`ifdef LCD_INIT_TIMEOUT_EN
        check("err_clear", init_err, 0);
        @(negedge CLK);
        mode = 2; host.valid = 1'b0; reinit = 1'b1;
        @(negedge CLK);
        reinit = 1'b0;
        #2;
        n = 0;
        while (!tx.valid && n < 200) begin n++; tick(); end
        check("to_first_valid", tx.valid, 1);
        check("to_first_data", tx.data, 8'h11);
        n = 0;
        while (tx.valid && n < 100) begin n++; tick(); end
        check("to_stall_len", n, 16);
        check("to_err", init_err, 1);
        check("to_valid", tx.valid, 0);
        check("to_done", init_done, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_init_sequencer.md
Name: lcd_init_sequencer

Overview:
Table-driven controller for the 0.96" SPI LCD. It pulses the panel reset pin and walks a command ROM of command bytes, parameters and post-command delays. Each byte goes to the downstream SPI byte writer (owner of SCL/MOSI/CS) over a valid/ready handshake that carries a DC flag. Once the table is exhausted, the block hands the byte writer to a host requester (pixel/drawing logic) and stays in pass-through mode.

Parameters:
RST_PULSE_CYC, 120, cycles LCD_RST is held low (10 us at 12 MHz)
RST_WAIT_CYC, 60000, cycles waited after LCD_RST rises (5 ms)
DELAY_UNIT_CYC, 12000, cycles per ROM delay unit (1 ms)
ROM_DEPTH, 32, command ROM bytes; pointer width = clog2(ROM_DEPTH)
TIMEOUT_CYC, 65535, stall limit, used only with the optional feature

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
reinit  in  1  single-cycle request to rerun the full init sequence
LCD_RST  out  1  panel reset pin, active low
tx_valid  out  1  byte available to SPI writer
tx_dc  out  1  0 = command byte, 1 = parameter/pixel data
tx_data  out  8  byte to send
tx_ready  in  1  SPI writer accepts byte when tx_valid && tx_ready
host_valid  in  1  host byte available
host_dc  in  1  host DC flag
host_data  in  8  host byte
host_ready  out  1  host byte accepted when host_valid && host_ready
init_done  out  1  high while in RUN

Behaviour:
- Reset is synchronous and active-high. While RESET is high: state = RST_ASSERT, counters = 0, ROM pointer = 0, LCD_RST = 0, tx_valid = 0, host_ready = 0, init_done = 0. RESET overrides every other input.
- ROM format is a byte stream. Each entry is CMD, then ARG, then ARG[3:0] parameter bytes, then one delay byte if ARG[7]=1. ARG[6:4] is ignored. A CMD of 0x00 terminates the table.
- Default ROM contents: 11 80 78 | B1 03 05 3C 3C | 3A 01 05 | 29 80 14 | 00. Unused bytes = 00.
- ROM reads are combinational from the pointer. Each FSM state consumes at most one byte.
- FSM states:
  - RST_ASSERT: LCD_RST=0 for exactly RST_PULSE_CYC cycles after RESET falls, then LCD_RST=1 and go to RST_WAIT.
  - RST_WAIT: wait RST_WAIT_CYC cycles, then go to FETCH_CMD.
  - FETCH_CMD: if byte==00, go to RUN. Otherwise latch CMD, advance pointer, go to FETCH_ARG.
  - FETCH_ARG: latch param count and delay flag, advance pointer, go to SEND_CMD.
  - SEND_CMD: tx_valid=1, tx_dc=0, tx_data=CMD. On handshake: if count>0 go to SEND_PARAM; else if delay flag set go to LOAD_DLY; else go to FETCH_CMD.
  - SEND_PARAM: tx_valid=1, tx_dc=1, tx_data=ROM[ptr]. On handshake: advance pointer and decrement count. When count reaches 0, go to LOAD_DLY or FETCH_CMD as above.
  - LOAD_DLY: latch delay byte, advance pointer. A value of 0 means no wait; go straight to FETCH_CMD.
  - DELAY: wait delay×DELAY_UNIT_CYC cycles, then go to FETCH_CMD.
  - RUN: init_done=1. tx_valid=host_valid, tx_dc=host_dc, tx_data=host_data, host_ready=tx_ready, all combinational pass-through with zero latency.
- Handshake rules: once tx_valid is raised in an init state, tx_valid, tx_dc and tx_data stay stable until accepted. tx_valid never deasserts without a handshake. host_ready=0 in every state except RUN.
- Delays count from the cycle of the final byte handshake. They do not wait for the SPI shift to complete.
- reinit is honoured only in RUN. The next cycle enters RST_ASSERT with init_done=0 and pointer=0. Any host byte handshaken in that same cycle is still delivered. reinit is ignored in every other state.
- Pointer reaching ROM_DEPTH-1 without a terminator: the next fetch is treated as 00, and the block goes to RUN.
- Delay counter width is 8 + clog2(DELAY_UNIT_CYC+1) bits, with no overflow.

Optional Feature:
LCD_INIT_TIMEOUT_EN:
- Defined: adds output port init_err (1 bit, reset 0, sticky until RESET or reinit). In SEND_CMD or SEND_PARAM, if tx_ready stays low for TIMEOUT_CYC consecutive cycles, the block drops tx_valid, sets init_err=1 and enters RUN, so the host is not deadlocked.
- Undefined: no init_err port, and the block waits indefinitely for tx_ready.

Test Plan:
1. Reset timing, RST_PULSE_CYC=4, RST_WAIT_CYC=8, DELAY_UNIT_CYC=2 → LCD_RST is low exactly 4 cycles after RESET falls. First tx_valid appears 8 cycles after LCD_RST rises plus 2 fetch cycles.
2. Full table with tx_ready tied to 1 → (dc,data) sequence is (0,11) (0,B1) (1,05) (1,3C) (1,3C) (0,3A) (1,05) (0,29). There are 240 idle cycles after 11 and 40 after 29, then init_done=1.
3. Backpressure: tx_ready toggles 1-of-3 cycles → same byte sequence; tx_data/tx_dc stay stable while tx_valid && !tx_ready; no byte is dropped or duplicated.
4. Host access: host_valid=1, data=AA, dc=1 during init → host_ready=0, no AA on tx. After init_done → tx_data=AA, tx_dc=1, host_ready follows tx_ready in the same cycle.
5. reinit pulse in RUN → init_done falls next cycle, LCD_RST low 4 cycles, and the table replays starting at (0,11). reinit during DELAY → ignored.
6. With LCD_INIT_TIMEOUT_EN and TIMEOUT_CYC=16, tx_ready held 0 → after 16 stalled cycles on (0,11): init_err=1, tx_valid=0, init_done=1.
